// File: rtl/band_playback_engine.sv
// band_playback_engine
// Sample-playback sequencer for band/loop ROMs. It drives the address of an
// external synchronous-read BRAM and emits one signed sample per 44 kHz
// enable strobe. It supports start/stop control, sub-range playback, loop or
// one-shot mode, read-latency tracking, and sticky status flags.
//
// Optional feature macro: PLAYBACK_GAIN_EN. When defined, it adds an 8-bit
// unsigned Q1.7 gain port (8'h80 = unity) with a symmetric saturating scale.
//
// Output handshake: valid_out is a 1-cycle qualifier for data_out. There is
// no ready/backpressure, and the mixer must take every qualified sample.
// data_out holds its value between pulses. The FSM state is held in state_q
// (type state_t) so checkers can bind to it directly.
module band_playback_engine #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4036,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
`ifdef PLAYBACK_GAIN_EN
  input  logic [7:0]        gain,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;

  localparam logic [2:0]      LAT_LD  = 3'(RD_LAT);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic              loop_q;
  logic [2:0]        rdy_cnt;

  logic              cfg_ok;
  logic              rdy;
  logic              at_end;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] sample;

  // Range check on the live start inputs, plus the address-advance helpers.
  always_comb begin
    cfg_ok    = (start_addr <= end_addr) && ({1'b0, end_addr} < DEPTH_X);
    rdy       = (rdy_cnt == 3'd0);
    at_end    = (mem_addr == end_q);
    next_addr = at_end ? start_q : mem_addr + ADDR_W'(1);
  end

`ifdef PLAYBACK_GAIN_EN
  localparam int PW = DATA_W + 9;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (DATA_W - 1)));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;

  // Q1.7 gain: widen both operands, scale, then clamp to the sample range.
  always_comb begin
    prod   = PW'($signed(mem_rdata)) * PW'($signed({1'b0, gain}));
    scaled = prod >>> 7;
    sample = scaled[DATA_W-1:0];
    if (scaled > SAT_MAX) begin
      sample = SAT_MAX[DATA_W-1:0];
    end else if (scaled < SAT_MIN) begin
      sample = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  // Without gain, the BRAM word passes through unchanged.
  always_comb begin
    sample = mem_rdata;
  end
`endif

  // Control FSM and all registered outputs. Priority is stop > start > enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= '0;
      end_q     <= '0;
      loop_q    <= 1'b0;
      rdy_cnt   <= 3'd0;
      mem_addr  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      // The read latency counter drains by default. An address change below reloads it.
      if (rdy_cnt != 3'd0) begin
        rdy_cnt <= rdy_cnt - 3'd1;
      end

      if (stop) begin
        state_q  <= IDLE;
        busy     <= 1'b0;
        data_out <= '0;
      end else if (start) begin
        if (cfg_ok) begin
          start_q  <= start_addr;
          end_q    <= end_addr;
          loop_q   <= loop_en;
          mem_addr <= start_addr;
          rdy_cnt  <= LAT_LD;
          state_q  <= PRIME;
          busy     <= 1'b1;
          underrun <= 1'b0;
          cfg_err  <= 1'b0;
        end else begin
          state_q <= IDLE;
          busy    <= 1'b0;
          cfg_err <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
          end
          PRIME: begin
            // Wait for the first word. Strobes arriving now are dropped.
            if (rdy) begin
              state_q <= PLAY;
            end
          end
          PLAY: begin
            if (enable) begin
              valid_out <= 1'b1;
              if (rdy) begin
                data_out <= sample;
                if (at_end && !loop_q) begin
                  done    <= 1'b1;
                  state_q <= IDLE;
                  busy    <= 1'b0;
                end else begin
                  mem_addr <= next_addr;
                  // A single-word loop keeps its address, so its data stays valid.
                  if (next_addr != mem_addr) begin
                    rdy_cnt <= LAT_LD;
                  end
                end
              end else begin
                // Data is late: repeat the last sample and flag the underrun.
                underrun <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_band_playback_engine.sv
// Bench for band_playback_engine (RD_LAT = 2, default depth).
// The reference model works in edge counts. A strobe plays once the engine
// has been primed (RD_LAT+1 edges after start), and it gets fresh data once
// RD_LAT+1 edges have passed since the last address move.
module tb_band_playback_engine;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 4036;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int RD_LAT    = 2;
  localparam int MEM_SZ    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_out;
  logic              valid_out, busy, done, underrun, cfg_err;
`ifdef PLAYBACK_GAIN_EN
  logic [7:0]        gain = 8'h80;
`endif

  band_playback_engine #(
    .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
`ifdef PLAYBACK_GAIN_EN
    .gain(gain),
`endif
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .done(done), .underrun(underrun),
    .cfg_err(cfg_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read BRAM with RD_LAT register stages
  logic [DATA_W-1:0] mem  [MEM_SZ];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Check bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_valid_seen = 0;
  int n_done_seen = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  logic              m_active, m_loop, m_valid, m_done, m_under, m_cfg;
  int                m_s, m_e, m_addr, m_start_edge, m_last_change;
  logic [DATA_W-1:0] m_data;

  task automatic model_reset();
    m_active = 0; m_loop = 0; m_valid = 0; m_done = 0; m_under = 0; m_cfg = 0;
    m_s = 0; m_e = 0; m_addr = 0; m_start_edge = 0; m_last_change = 0; m_data = '0;
    exp_q.delete();
  endtask

  function automatic logic [DATA_W-1:0] exp_sample(input logic [DATA_W-1:0] r);
`ifdef PLAYBACK_GAIN_EN
    int p;
    p = int'($signed(r)) * int'(gain);
    p = p >>> 7;
    if (p > (2 ** (DATA_W - 1)) - 1) p = (2 ** (DATA_W - 1)) - 1;
    if (p < -(2 ** (DATA_W - 1))) p = -(2 ** (DATA_W - 1));
    return p[DATA_W-1:0];
`else
    return r;
`endif
  endfunction

  // Predict the outputs that follow the upcoming clock edge
  task automatic model(input logic en, input logic st, input logic sp, input logic lp,
                       input int sa, input int ea);
    m_valid = 0;
    m_done  = 0;
    if (sp) begin
      m_active = 0;
      m_data   = '0;
    end else if (st) begin
      if (sa > ea || ea >= MEM_DEPTH) begin
        m_active = 0;
        m_cfg    = 1;
      end else begin
        m_active = 1; m_s = sa; m_e = ea; m_loop = lp; m_addr = sa;
        m_start_edge = cyc; m_last_change = cyc; m_under = 0; m_cfg = 0;
      end
    end else if (en && m_active && cyc >= m_start_edge + RD_LAT + 2) begin
      m_valid = 1;
      if (cyc >= m_last_change + RD_LAT + 1) begin
        m_data = exp_sample(mem[m_addr]);
        if (m_addr == m_e) begin
          if (m_loop) begin
            if (m_s != m_addr) m_last_change = cyc;
            m_addr = m_s;
          end else begin
            m_active = 0;
            m_done   = 1;
          end
        end else begin
          m_addr++;
          m_last_change = cyc;
        end
      end else begin
        m_under = 1;
      end
      exp_q.push_back(m_data);
    end
    cyc++;
  endtask

  // Driver: apply one cycle of inputs, then check everything after the edge
  task automatic step(input logic en, input logic st, input logic sp, input logic lp,
                      input int sa, input int ea);
    enable = en; start = st; stop = sp; loop_en = lp;
    start_addr = ADDR_W'(sa); end_addr = ADDR_W'(ea);
    model(en, st, sp, lp, sa, ea);
    @(negedge clk);
    enable = 0; start = 0; stop = 0;
    chk("data_out", data_out, m_data);
    chk("valid_out", valid_out, m_valid);
    chk("done", done, m_done);
    chk("busy", busy, m_active);
    chk("underrun", underrun, m_under);
    chk("cfg_err", cfg_err, m_cfg);
    chk("mem_addr", mem_addr, m_addr);
    if (valid_out) begin
      n_valid_seen++;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_extra cyc=%0d got=%0h want=none", cyc, data_out);
      end else begin
        chk("sb_sample", data_out, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL sb_missing cyc=%0d got=none want=%0h", cyc, exp_q.pop_front());
    end
    if (done) n_done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int sa; int ea; logic lp; int n_en; int gap;
    logic exp_cfg; int exp_valid; int exp_done; logic exp_busy;
  } vec_t;
  vec_t tab[9];

  initial begin
    tab[0] = '{sa:0,    ea:3,    lp:1, n_en:6, gap:100, exp_cfg:0, exp_valid:6, exp_done:0, exp_busy:1};
    tab[1] = '{sa:10,   ea:12,   lp:0, n_en:3, gap:20,  exp_cfg:0, exp_valid:3, exp_done:1, exp_busy:0};
    tab[2] = '{sa:10,   ea:12,   lp:0, n_en:5, gap:20,  exp_cfg:0, exp_valid:3, exp_done:1, exp_busy:0};
    tab[3] = '{sa:5,    ea:4,    lp:0, n_en:3, gap:10,  exp_cfg:1, exp_valid:0, exp_done:0, exp_busy:0};
    tab[4] = '{sa:7,    ea:7,    lp:1, n_en:4, gap:10,  exp_cfg:0, exp_valid:4, exp_done:0, exp_busy:1};
    tab[5] = '{sa:7,    ea:7,    lp:0, n_en:2, gap:10,  exp_cfg:0, exp_valid:1, exp_done:1, exp_busy:0};
    tab[6] = '{sa:4030, ea:4035, lp:0, n_en:6, gap:10,  exp_cfg:0, exp_valid:6, exp_done:1, exp_busy:0};
    tab[7] = '{sa:4030, ea:4036, lp:1, n_en:3, gap:10,  exp_cfg:1, exp_valid:0, exp_done:0, exp_busy:0};
    tab[8] = '{sa:100,  ea:4095, lp:0, n_en:3, gap:10,  exp_cfg:1, exp_valid:0, exp_done:0, exp_busy:0};

    for (int i = 0; i < MEM_SZ; i++) mem[i] = DATA_W'($urandom()) | DATA_W'(1);

    // Reset block: every output must be zero while rst_n is held low
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    idle(2);

    // Table-driven range/mode vectors
    for (int v = 0; v < 9; v++) begin
      step(0, 0, 1, 0, 0, 0);
      n_valid_seen = 0;
      n_done_seen  = 0;
      step(0, 1, 0, tab[v].lp, tab[v].sa, tab[v].ea);
      for (int k = 0; k < tab[v].n_en; k++) begin
        idle(tab[v].gap - 1);
        step(1, 0, 0, 0, 0, 0);
      end
      idle(2);
      chk("vec_valid_count", n_valid_seen, tab[v].exp_valid);
      chk("vec_done_count", n_done_seen, tab[v].exp_done);
      chk("vec_busy", busy, tab[v].exp_busy);
      chk("vec_cfg_err", cfg_err, tab[v].exp_cfg);
    end

    // A strobe during PRIME is ignored. A strobe right after an advance underruns.
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 20, 29);
    step(1, 0, 0, 0, 0, 0);
    chk("prime_valid", valid_out, 0);
    chk("prime_underrun", underrun, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0);
    chk("first_sample", data_out, mem[20]);
    step(1, 0, 0, 0, 0, 0);
    chk("repeat_valid", valid_out, 1);
    chk("repeat_sample", data_out, mem[20]);
    chk("underrun_set", underrun, 1);
    idle(3);
    step(1, 0, 0, 0, 0, 0);
    chk("resume_sample", data_out, mem[21]);
    chk("underrun_sticky", underrun, 1);

    // A bad range sets cfg_err. The next good start clears both sticky bits.
    step(0, 1, 0, 0, 5, 4);
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_busy_low", busy, 0);
    step(0, 1, 0, 1, 0, 3);
    chk("cfg_err_clear", cfg_err, 0);
    chk("underrun_clear", underrun, 0);
    chk("restart_busy", busy, 1);

    // stop and start in the same cycle mid-PLAY: stop wins
    idle(4);
    step(1, 0, 0, 0, 0, 0);
    chk("pre_stop_data", data_out, mem[0]);
    step(1, 1, 1, 1, 0, 3);
    chk("stop_busy", busy, 0);
    chk("stop_data_zero", data_out, 0);
    chk("stop_no_done", done, 0);
    idle(5);
    chk("stop_stays_idle", busy, 0);

    // Asynchronous reset mid-PLAY clears outputs without a clock edge
    step(0, 1, 0, 1, 30, 35);
    idle(4);
    step(1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data_out", data_out, 0);
    chk("arst_valid_out", valid_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(2);

`ifdef PLAYBACK_GAIN_EN
    // Gain saturation and scaling
    mem[40] = 16'h7000;
    mem[41] = 16'hC000;
    step(0, 1, 0, 0, 40, 41);
    idle(4);
    gain = 8'hFF;
    step(1, 0, 0, 0, 0, 0);
    chk("gain_sat_pos", data_out, 16'h7FFF);
    idle(3);
    gain = 8'h40;
    step(1, 0, 0, 0, 0, 0);
    chk("gain_half_neg", data_out, 16'hE000);
    chk("gain_done", done, 1);
    gain = 8'h80;
`endif

    // Randomized control traffic checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      int r, sa, ea;
      logic en, st, sp, lp;
      r  = $urandom_range(0, 199);
      sp = (r < 2);
      st = (r >= 2 && r < 6);
      en = ($urandom_range(0, 5) == 0);
      lp = 1'($urandom_range(0, 1));
      sa = $urandom_range(0, 40);
      ea = sa + $urandom_range(0, 8);
      if ($urandom_range(0, 9) == 0) begin
        sa = $urandom_range(4020, 4040);
        ea = $urandom_range(4020, MEM_SZ - 1);
      end
`ifdef PLAYBACK_GAIN_EN
      if (en) gain = 8'($urandom_range(0, 255));
`endif
      step(en, st, sp, lp, sa, ea);
    end

    idle(2);
    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
